// File: rtl/key_debounce_pulse.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce_pulse
//  Purpose  : Synchronizes and debounces an active-low pushbutton. Produces a
//             clean held level and single-cycle press strobes, with optional
//             hold-to-repeat strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module key_debounce_pulse #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic Clock,
   input  logic Reset,
   input  logic KeyN,
   output logic Pressed,
   output logic Pulse
);

   localparam int c_DB_W     = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int c_RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int c_RPT_W    = (c_RPT_MAX > 2) ? $clog2(c_RPT_MAX) : 1;

   localparam logic [c_DB_W-1:0]  c_DB_TERM     = c_DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_RPT_W-1:0] c_DELAY_TERM  = c_RPT_W'(REPEAT_DELAY - 1);
   localparam logic [c_RPT_W-1:0] c_PERIOD_TERM = c_RPT_W'(REPEAT_PERIOD - 1);
   localparam logic [c_RPT_W-1:0] c_RPT_SAT     = c_RPT_W'(c_RPT_MAX - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HELD   = 2'd1,
      S_REPEAT = 2'd2
   } state_t;

   // Synchronizer / debounce
   logic                r_sync1;
   logic                r_key_s;
   logic                r_accepted;   // accepted key level, 1 = released
   logic [c_DB_W-1:0]   r_db_cnt;
   logic                w_mismatch;
   logic                w_db_done;
   logic                w_press_acc;
   logic                w_rel_acc;

   // Press / repeat FSM
   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_pressed;
   logic                w_pressed_nxt;
   logic                r_pulse;
   logic                w_pulse_nxt;
   logic [c_RPT_W-1:0]  r_rpt_cnt;
   logic [c_RPT_W-1:0]  w_rpt_nxt;
   logic [c_RPT_W-1:0]  w_rpt_inc;

   // Two-stage synchronizer; both stages idle high (released)
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_sync1 <= 1'b1;
         r_key_s <= 1'b1;
      end else begin
         r_sync1 <= KeyN;
         r_key_s <= r_sync1;
      end
   end

   assign w_mismatch  = (r_key_s != r_accepted);
   assign w_db_done   = w_mismatch && (r_db_cnt == c_DB_TERM);
   assign w_press_acc = w_db_done && r_accepted;
   assign w_rel_acc   = w_db_done && !r_accepted;

   // Stability counter: any agreement restarts it, a full run flips the accepted level
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_db_cnt   <= '0;
         r_accepted <= 1'b1;
      end else if (!w_mismatch) begin
         r_db_cnt   <= '0;
      end else if (w_db_done) begin
         r_db_cnt   <= '0;
         r_accepted <= ~r_accepted;
      end else begin
         r_db_cnt   <= r_db_cnt + c_DB_W'(1);
      end
   end

   // Saturating increment so the repeat timer can never wrap
   assign w_rpt_inc = (r_rpt_cnt == c_RPT_SAT) ? r_rpt_cnt : (r_rpt_cnt + c_RPT_W'(1));

   // FSM state, level, strobe and repeat-timer registers
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state   <= S_IDLE;
         r_pressed <= 1'b0;
         r_pulse   <= 1'b0;
         r_rpt_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_pressed <= w_pressed_nxt;
         r_pulse   <= w_pulse_nxt;
         r_rpt_cnt <= w_rpt_nxt;
      end
   end

   // Next-state logic; a release always takes priority over a repeat terminal count
   always_comb begin
      w_state_nxt   = r_state;
      w_pressed_nxt = r_pressed;
      w_pulse_nxt   = 1'b0;
      w_rpt_nxt     = r_rpt_cnt;
      case (r_state)
         S_IDLE: begin
            w_rpt_nxt = '0;
            if (w_press_acc) begin
               w_state_nxt   = S_HELD;
               w_pressed_nxt = 1'b1;
               w_pulse_nxt   = 1'b1;
            end
         end
         S_HELD: begin
            if (w_rel_acc) begin
               w_state_nxt   = S_IDLE;
               w_pressed_nxt = 1'b0;
               w_rpt_nxt     = '0;
            end else if (REPEAT_EN == 0) begin
               w_rpt_nxt     = '0;
            end else if (r_rpt_cnt == c_DELAY_TERM) begin
               w_state_nxt   = S_REPEAT;
               w_pulse_nxt   = 1'b1;
               w_rpt_nxt     = '0;
            end else begin
               w_rpt_nxt     = w_rpt_inc;
            end
         end
         S_REPEAT: begin
            if (w_rel_acc) begin
               w_state_nxt   = S_IDLE;
               w_pressed_nxt = 1'b0;
               w_rpt_nxt     = '0;
            end else if (r_rpt_cnt == c_PERIOD_TERM) begin
               w_pulse_nxt   = 1'b1;
               w_rpt_nxt     = '0;
            end else begin
               w_rpt_nxt     = w_rpt_inc;
            end
         end
         default: begin
            w_state_nxt   = S_IDLE;
            w_pressed_nxt = 1'b0;
            w_rpt_nxt     = '0;
         end
      endcase
   end

   assign Pressed = r_pressed;
   assign Pulse   = r_pulse;

endmodule
`default_nettype wire
